cache_access_driver: RTL and testbench

//  Initiator for the cache's CPU-side port (Mem_read/Mem_write/Address/Data_in -> Stall/Data_out).

---
 rtl/cache_pkg.sv | 25 ++
 rtl/cache_access_driver_req_fifo.sv | 59 +++++
 rtl/cache_access_driver.sv | 155 +++++++++++++++
 tb/tb_cache_access_driver.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// cache_pkg
//   Shared widths and types for the cache access driver.
//   ADDR_W / DATA_W : cache CPU-port address and data widths
//   REQ_W           : packed width of one buffered request
//   state_t         : driver FSM states
//   req_t           : buffered request {write, addr, wdata}
package cache_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int REQ_W  = 1 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    GAP   = 2'd2
  } state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/cache_access_driver_req_fifo.sv
// req_fifo
//   Synchronous request FIFO, DEPTH entries of WIDTH bits, first-word
//   fall-through: rd_data always shows the head entry.
//   Ports:
//     clk, reset      clock, asynchronous active-low reset (flushes pointers)
//     push, wr_data   write one entry (ignored when full)
//     pop             drop the head entry (ignored when empty)
//     rd_data         head entry
//     full, empty     occupancy flags from the extra pointer wrap bit
module req_fifo
  import cache_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = REQ_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_reg [DEPTH];
  logic [PTR_W:0]   wr_ptr_reg;
  logic [PTR_W:0]   rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[PTR_W] != rd_ptr_reg[PTR_W]) &&
                   (wr_ptr_reg[PTR_W-1:0] == rd_ptr_reg[PTR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem_reg[rd_ptr_reg[PTR_W-1:0]];

  // Storage carries no reset; only the pointers define valid contents.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_reg[wr_ptr_reg[PTR_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

endmodule

// File: rtl/cache_access_driver.sv
// cache_access_driver
//   Initiator for the cache CPU-side port. Buffers upstream load/store
//   requests, issues them one at a time, holds each stable while the cache
//   stalls, and returns a one-cycle response per completed access.
//   Ports:
//     clk, reset                      clock, asynchronous active-low reset
//     req_valid/req_ready             upstream handshake (ready = FIFO not full)
//     req_write/req_addr/req_wdata    upstream request fields
//     rsp_valid/rsp_write/rsp_rdata   completion pulse, op type, load data
//     Mem_read/Mem_write/Address/Data_in  request to cache (registered)
//     Stall/Data_out                  cache status and read data
//     busy                            FIFO non-empty or access in flight
//     err                             sticky stall-timeout flag
//     acc_count                       completed accesses, wrapping
module cache_access_driver
  import cache_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              Mem_read,
  output logic              Mem_write,
  output logic [ADDR_W-1:0] Address,
  output logic [DATA_W-1:0] Data_in,
  input  logic              Stall,
  input  logic [DATA_W-1:0] Data_out,
  output logic              busy,
  output logic              err,
  output logic [15:0]       acc_count
);

  localparam int               CNT_W       = 10;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  state_t            state_reg;
  logic              op_reg;
  logic              mem_read_reg;
  logic              mem_write_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] data_in_reg;
  logic              rsp_valid_reg;
  logic              rsp_write_reg;
  logic [DATA_W-1:0] rsp_rdata_reg;
  logic [CNT_W-1:0]  stall_cnt_reg;
  logic [CNT_W-1:0]  stall_cnt_next;
  logic              err_reg;
  logic [15:0]       acc_count_reg;

  req_t              push_req;
  logic [REQ_W-1:0]  head_bits;
  req_t              head_req;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;

  assign push_req  = '{write: req_write, addr: req_addr, wdata: req_wdata};
  assign head_req  = req_t'(head_bits);
  assign req_ready = !fifo_full;
  assign fifo_push = req_valid && req_ready;
  assign fifo_pop  = (state_reg == IDLE) && !fifo_empty;

  req_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REQ_W)
  ) u_req_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (fifo_push),
    .wr_data (push_req),
    .pop     (fifo_pop),
    .rd_data (head_bits),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Saturating stall counter so a long stall cannot wrap back below TIMEOUT.
  assign stall_cnt_next = (stall_cnt_reg == CNT_MAX) ? stall_cnt_reg
                                                     : stall_cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      op_reg        <= 1'b0;
      mem_read_reg  <= 1'b0;
      mem_write_reg <= 1'b0;
      addr_reg      <= '0;
      data_in_reg   <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_write_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      stall_cnt_reg <= '0;
      err_reg       <= 1'b0;
      acc_count_reg <= '0;
    end else begin
      rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!fifo_empty) begin
            op_reg        <= head_req.write;
            addr_reg      <= head_req.addr;
            data_in_reg   <= head_req.write ? head_req.wdata : '0;
            mem_read_reg  <= !head_req.write;
            mem_write_reg <= head_req.write;
            stall_cnt_reg <= '0;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          if (!Stall) begin
            mem_read_reg  <= 1'b0;
            mem_write_reg <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_write_reg <= op_reg;
            rsp_rdata_reg <= op_reg ? '0 : Data_out;
            acc_count_reg <= acc_count_reg + 1'b1;
            state_reg     <= GAP;
          end else begin
            // Timeout only flags the condition; the access keeps waiting.
            stall_cnt_reg <= stall_cnt_next;
            if (stall_cnt_next == TIMEOUT_CNT) err_reg <= 1'b1;
          end
        end
        GAP: begin
          // One quiet cycle lets the cache controller return to idle.
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign Mem_read  = mem_read_reg;
  assign Mem_write = mem_write_reg;
  assign Address   = addr_reg;
  assign Data_in   = data_in_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_write = rsp_write_reg;
  assign rsp_rdata = rsp_rdata_reg;
  assign err       = err_reg;
  assign acc_count = acc_count_reg;
  assign busy      = !fifo_empty || (state_reg != IDLE);

endmodule

// File: tb/tb_cache_access_driver.sv
// tb_cache_access_driver
//   Directed bench for cache_access_driver: inputs driven and outputs sampled
//   on the falling edge; the bench plays the cache by driving Stall/Data_out.
module tb_cache_access_driver;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [9:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        Mem_read;
  logic        Mem_write;
  logic [9:0]  Address;
  logic [31:0] Data_in;
  logic        Stall = 1'b0;
  logic [31:0] Data_out = '0;
  logic        busy;
  logic        err;
  logic [15:0] acc_count;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cache_access_driver #(.DEPTH(4), .TIMEOUT(1023)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata),
    .Mem_read  (Mem_read),
    .Mem_write (Mem_write),
    .Address   (Address),
    .Data_in   (Data_in),
    .Stall     (Stall),
    .Data_out  (Data_out),
    .busy      (busy),
    .err       (err),
    .acc_count (acc_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // One-cycle push starting at the next falling edge; returns on the
  // falling edge after the accepting rising edge.
  task automatic push_req(input logic w, input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_mem(input int max_cyc, output bit ok);
    for (int k = 0; k < max_cyc && !(Mem_read || Mem_write); k++) @(negedge clk);
    ok = Mem_read || Mem_write;
  endtask

  task automatic wait_rsp(input int max_cyc, output bit ok);
    for (int k = 0; k < max_cyc && !rsp_valid; k++) @(negedge clk);
    ok = rsp_valid;
  endtask

  initial begin
    bit ok;
    bit activity;
    logic        exp_w;
    logic [9:0]  exp_a;
    logic [31:0] exp_d;

    // ---------------- reset state ----------------
    @(negedge clk);
    check("rst_ready", req_ready, 1'b1);
    check("rst_outs", {rsp_valid, rsp_write, rsp_rdata, Mem_read, Mem_write, Address, Data_in, busy, err, acc_count},
          {1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 16'h0});
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // ---------------- single load hit ----------------
    Stall    = 1'b0;
    Data_out = 32'hDEADBEEF;
    push_req(1'b0, 10'h004, 32'h0);
    check("ld_wait_pop", {Mem_read, busy}, {1'b0, 1'b1});
    @(negedge clk);
    check("ld_issue", {Mem_read, Mem_write, Address, Data_in, rsp_valid}, {1'b1, 1'b0, 10'h004, 32'h0, 1'b0});
    @(negedge clk);
    check("ld_rsp", {rsp_valid, rsp_write, rsp_rdata, Mem_read, acc_count}, {1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 16'd1});
    @(negedge clk);
    check("ld_done", {rsp_valid, busy}, {1'b0, 1'b0});

    // ---------------- store stalled 5 cycles ----------------
    Stall = 1'b1;
    push_req(1'b1, 10'h3FF, 32'h12345678);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("st_hold%0d", i), {Mem_read, Mem_write, Address, Data_in, rsp_valid},
            {1'b0, 1'b1, 10'h3FF, 32'h12345678, 1'b0});
      if (i == 5) Stall = 1'b0;
    end
    @(negedge clk);
    check("st_rsp", {rsp_valid, rsp_write, rsp_rdata, Mem_write, acc_count}, {1'b1, 1'b1, 32'h0, 1'b0, 16'd2});

    // ---------------- 5 back-to-back pushes, cache stalled ----------------
    // The first entry is popped one edge after it lands, so four pushes leave
    // three queued and the fifth push fills the FIFO.
    Stall = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_write = i[0];
      req_addr  = 10'h010 + 10'(i);
      req_wdata = 32'h1000 + 32'(i);
      @(negedge clk);
      if (i == 3) check("bb_ready_after4", req_ready, 1'b1);
    end
    check("bb_full_after5", req_ready, 1'b0);
    // A sixth request offered while full must not be taken.
    req_write = 1'b0;
    req_addr  = 10'h1EE;
    @(negedge clk);
    req_valid = 1'b0;
    check("bb_still_full", req_ready, 1'b0);

    Stall = 1'b0;
    for (int i = 0; i < 5; i++) begin
      exp_w = i[0];
      exp_a = 10'h010 + 10'(i);
      exp_d = exp_w ? 32'h1000 + 32'(i) : 32'h0;
      wait_mem(20, ok);
      check($sformatf("bb_issue_seen%0d", i), ok, 1'b1);
      check($sformatf("bb_issue%0d", i), {Mem_read, Mem_write, Address, Data_in}, {!exp_w, exp_w, exp_a, exp_d});
      Data_out = 32'hC0DE0000 + 32'(i);
      @(negedge clk);
      check($sformatf("bb_rsp%0d", i), {rsp_valid, rsp_write, rsp_rdata, Mem_read, Mem_write},
            {1'b1, exp_w, exp_w ? 32'h0 : 32'hC0DE0000 + 32'(i), 1'b0, 1'b0});
    end
    repeat (4) @(negedge clk);
    check("bb_drained", {busy, acc_count}, {1'b0, 16'd7});

    // ---------------- stall timeout ----------------
    Stall = 1'b1;
    push_req(1'b0, 10'h055, 32'h0);
    repeat (1000) @(negedge clk);
    check("to_err_early", err, 1'b0);
    repeat (30) @(negedge clk);
    check("to_err_set", {err, Mem_read, Address}, {1'b1, 1'b1, 10'h055});
    Stall    = 1'b0;
    Data_out = 32'h0BADF00D;
    wait_rsp(5, ok);
    check("to_rsp_seen", ok, 1'b1);
    check("to_rsp", {rsp_rdata, err, acc_count}, {32'h0BADF00D, 1'b1, 16'd8});
    repeat (3) @(negedge clk);
    check("to_err_sticky", err, 1'b1);

    // ---------------- async reset mid-ISSUE ----------------
    Stall = 1'b1;
    push_req(1'b1, 10'h0AA, 32'hCAFEF00D);
    push_req(1'b0, 10'h0BB, 32'h0);
    @(negedge clk);
    check("ar_in_issue", {Mem_write, Address}, {1'b1, 10'h0AA});
    #2 reset = 1'b0;
    #1;
    check("ar_outs", {Mem_read, Mem_write, Address, Data_in, busy, err, req_ready, rsp_valid, acc_count},
          {1'b0, 1'b0, 10'h0, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0});
    Stall = 1'b0;
    activity = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      activity = activity | Mem_read | Mem_write | rsp_valid | busy;
    end
    check("ar_flushed", activity, 1'b0);

    // ---------------- acc_count wrap ----------------
    force dut.acc_count_reg = 16'hFFFF;
    @(negedge clk);
    release dut.acc_count_reg;
    @(negedge clk);
    check("wr_preload", acc_count, 16'hFFFF);
    Data_out = 32'h00000004;
    push_req(1'b0, 10'h004, 32'h0);
    wait_rsp(10, ok);
    check("wr_rsp_seen", ok, 1'b1);
    check("wr_wrapped", {acc_count, rsp_rdata}, {16'h0000, 32'h00000004});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
